// File: rtl/icache_wb_top.sv
// icache_wb_top: direct-mapped read-only instruction cache between a Wishbone CPU port and a burst memory port.
// 16 lines of 32 words each, optional next-line prefetch after every demand refill.
module icache_wb_top #(
  parameter int WB_AW      = 32,
  parameter int WB_DW      = 32,
  parameter int TAG_MEM_WD = 22,
  parameter int TAG_MEM_DP = 16,
  parameter int CACHELINES = 16,
  parameter int CACHESIZE  = 32
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             cfg_pfet_dis,
  input  logic             cfg_ntag_pfet_dis,
  input  logic             wb_cpu_stb_i,
  input  logic [WB_AW-1:0] wb_cpu_adr_i,
  input  logic             wb_cpu_we_i,
  input  logic [WB_DW-1:0] wb_cpu_dat_i,
  input  logic [3:0]       wb_cpu_sel_i,
  output logic [WB_DW-1:0] wb_cpu_dat_o,
  output logic             wb_cpu_ack_o,
  output logic             wb_cpu_err_o,
  output logic             wb_app_stb_o,
  output logic [WB_AW-1:0] wb_app_adr_o,
  output logic             wb_app_we_o,
  output logic [WB_DW-1:0] wb_app_dat_o,
  output logic [3:0]       wb_app_sel_o,
  output logic [9:0]       wb_app_bl_o,
  input  logic [WB_DW-1:0] wb_app_dat_i,
  input  logic             wb_app_ack_i,
  input  logic             wb_app_lack_i,
  input  logic             wb_app_err_i
);
  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, REFILL, DONE, PREFETCH} state_t;
  state_t                r_state;
  logic [31:2]           r_adr;
  logic [TAG_MEM_WD-1:0] r_tag [TAG_MEM_DP];
  logic [WB_DW-1:0]      r_mem [CACHELINES*CACHESIZE];
  logic [WB_DW-1:0]      r_rd;
  logic [WB_DW-1:0]      r_dat;
  logic [WB_AW-1:0]      r_app_adr;
  logic                  r_app_stb;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_pfq;
  logic [4:0]            r_cnt;
  logic [WB_AW-1:0]      w_line;
  logic [WB_AW-1:0]      w_nadr;
  logic                  w_hit;
  logic                  w_nhit;
  logic                  w_wr;
  logic                  w_pf;
  logic                  w_unused;
  assign w_line   = {r_adr[31:7], 7'b0};
  assign w_nadr   = w_line + 32'd128;
  assign w_hit    = r_tag[r_adr[10:7]] == {1'b1, r_adr[31:11]};
  assign w_nhit   = r_tag[w_nadr[10:7]] == {1'b1, w_nadr[31:11]};
  assign w_wr     = rst_n && (r_state == REFILL || r_state == PREFETCH) && wb_app_ack_i && !wb_app_err_i;
  assign w_pf     = r_pfq && !cfg_pfet_dis && !w_nhit && !(cfg_ntag_pfet_dis && r_adr[10:7] == 4'hF);
  assign w_unused = ^{wb_cpu_dat_i, wb_cpu_sel_i, wb_cpu_adr_i[1:0]};
  assign wb_cpu_dat_o = r_dat;
  assign wb_cpu_ack_o = r_ack;
  assign wb_cpu_err_o = r_err;
  assign wb_app_stb_o = r_app_stb;
  assign wb_app_adr_o = r_app_adr;
  assign wb_app_we_o  = 1'b0;
  assign wb_app_dat_o = '0;
  assign wb_app_sel_o = r_app_stb ? 4'hF : 4'h0;
  assign wb_app_bl_o  = r_app_stb ? 10'(CACHESIZE) : 10'd0;
  // Re-reading in LOOKUP picks up words written by the refill that just finished.
  always_ff @(posedge mclk) begin
    if (w_wr) r_mem[{r_app_adr[10:7], r_cnt}] <= wb_app_dat_i;
    r_rd <= r_mem[r_state == IDLE ? wb_cpu_adr_i[10:2] : r_adr[10:2]];
  end
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_dat     <= '0;
      r_app_stb <= 1'b0;
      r_app_adr <= '0;
      r_cnt     <= '0;
      r_pfq     <= 1'b0;
      for (int i = 0; i < TAG_MEM_DP; i++) r_tag[i][TAG_MEM_WD-1] <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: if (wb_cpu_stb_i) begin
          r_adr   <= wb_cpu_adr_i[31:2];
          r_err   <= wb_cpu_we_i;
          r_state <= wb_cpu_we_i ? DONE : LOOKUP;
        end
        LOOKUP: if (w_hit) r_state <= RESP;
        else begin
          r_state   <= REFILL;
          r_app_stb <= 1'b1;
          r_app_adr <= w_line;
          r_cnt     <= '0;
          r_tag[r_adr[10:7]][TAG_MEM_WD-1] <= 1'b0;
        end
        RESP: begin
          r_ack   <= 1'b1;
          r_dat   <= r_rd;
          r_state <= DONE;
        end
        DONE: begin
          r_pfq <= 1'b0;
          if (w_pf) begin
            r_state   <= PREFETCH;
            r_app_stb <= 1'b1;
            r_app_adr <= w_nadr;
            r_cnt     <= '0;
            r_tag[w_nadr[10:7]][TAG_MEM_WD-1] <= 1'b0;
          end else r_state <= IDLE;
        end
        REFILL, PREFETCH: if (wb_app_err_i) begin
          r_app_stb <= 1'b0;
          r_err     <= r_state == REFILL;
          r_state   <= r_state == REFILL ? DONE : IDLE;
        end else if (wb_app_ack_i) begin
          r_cnt <= r_cnt + 5'd1;
          if (wb_app_lack_i) begin
            r_app_stb <= 1'b0;
            r_tag[r_app_adr[10:7]] <= {1'b1, r_app_adr[31:11]};
            r_pfq   <= r_state == REFILL;
            r_state <= r_state == REFILL ? LOOKUP : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_wb_top.sv
// tb_icache_wb_top: random-gap burst memory plus a tag-level cache model checking hits, refills, prefetch and errors.
module tb_icache_wb_top;
  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_pfet_dis = 1'b1;
  logic        cfg_ntag_pfet_dis = 1'b0;
  logic        wb_cpu_stb_i = 1'b0;
  logic [31:0] wb_cpu_adr_i = '0;
  logic        wb_cpu_we_i = 1'b0;
  logic [31:0] wb_cpu_dat_i = 32'hDEAD_BEEF;
  logic [3:0]  wb_cpu_sel_i = 4'hF;
  logic [31:0] wb_cpu_dat_o;
  logic        wb_cpu_ack_o;
  logic        wb_cpu_err_o;
  logic        wb_app_stb_o;
  logic [31:0] wb_app_adr_o;
  logic        wb_app_we_o;
  logic [31:0] wb_app_dat_o;
  logic [3:0]  wb_app_sel_o;
  logic [9:0]  wb_app_bl_o;
  logic [31:0] wb_app_dat_i;
  logic        wb_app_ack_i;
  logic        wb_app_lack_i;
  logic        wb_app_err_i;

  icache_wb_top dut (
    .mclk(mclk), .rst_n(rst_n), .cfg_pfet_dis(cfg_pfet_dis), .cfg_ntag_pfet_dis(cfg_ntag_pfet_dis),
    .wb_cpu_stb_i(wb_cpu_stb_i), .wb_cpu_adr_i(wb_cpu_adr_i), .wb_cpu_we_i(wb_cpu_we_i),
    .wb_cpu_dat_i(wb_cpu_dat_i), .wb_cpu_sel_i(wb_cpu_sel_i), .wb_cpu_dat_o(wb_cpu_dat_o),
    .wb_cpu_ack_o(wb_cpu_ack_o), .wb_cpu_err_o(wb_cpu_err_o), .wb_app_stb_o(wb_app_stb_o),
    .wb_app_adr_o(wb_app_adr_o), .wb_app_we_o(wb_app_we_o), .wb_app_dat_o(wb_app_dat_o),
    .wb_app_sel_o(wb_app_sel_o), .wb_app_bl_o(wb_app_bl_o), .wb_app_dat_i(wb_app_dat_i),
    .wb_app_ack_i(wb_app_ack_i), .wb_app_lack_i(wb_app_lack_i), .wb_app_err_i(wb_app_err_i)
  );

  always #5 mclk = ~mclk;

  int n_chk = 0;
  int n_pass = 0;
  int adr_bad = 0;
  int both_bad = 0;
  int inj = -1;
  int err_at = 0;
  int nexp = 0;
  int b_idx = 0;
  bit prev_drained = 1'b1;
  logic [31:0] burst_q[$];
  logic [31:0] exp_q[$];
  bit          vld[16];
  logic [20:0] tg_m[16];

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", t, got, exp);
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[31:2], 2'b00} * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  always @(negedge mclk) if (wb_cpu_ack_o && wb_cpu_err_o) both_bad++;

  // Burst memory: random ack gaps, optional error on one chosen burst.
  initial begin
    logic [31:0] cur;
    int n;
    int my_b;
    bit in_b;
    cur = '0; n = 0; my_b = 0; in_b = 1'b0;
    wb_app_ack_i = 1'b0; wb_app_lack_i = 1'b0; wb_app_err_i = 1'b0; wb_app_dat_i = '0;
    forever begin
      @(negedge mclk);
      if (!wb_app_stb_o || !rst_n) begin
        wb_app_ack_i = 1'b0; wb_app_lack_i = 1'b0; wb_app_err_i = 1'b0;
        in_b = 1'b0; n = 0;
      end else begin
        if (!in_b) begin
          in_b = 1'b1;
          cur = wb_app_adr_o;
          my_b = b_idx;
          b_idx++;
          burst_q.push_back(cur);
          chk("app_bl", 64'(wb_app_bl_o), 64'd32);
          chk("app_sel", 64'(wb_app_sel_o), 64'hF);
          chk("app_we_dat", 64'({wb_app_we_o, wb_app_dat_o}), 64'd0);
        end
        if (wb_app_adr_o != cur || wb_app_bl_o != 10'd32) adr_bad++;
        if (my_b == inj && n == err_at) begin
          wb_app_err_i = 1'b1; wb_app_ack_i = 1'b0; wb_app_lack_i = 1'b0;
        end else begin
          wb_app_err_i = 1'b0;
          wb_app_ack_i = ($urandom_range(0, 7) != 0) && n < 32;
          wb_app_dat_i = memw(cur + 32'(4 * n));
          wb_app_lack_i = wb_app_ack_i && n == 31;
          if (wb_app_ack_i) n++;
        end
      end
    end
  end

  task automatic cpu_req(input logic [31:0] a, input bit we, output logic [31:0] d,
                         output int acks, output int errs, output int lat, output int extra);
    @(negedge mclk);
    wb_cpu_stb_i = 1'b1; wb_cpu_adr_i = a; wb_cpu_we_i = we;
    acks = 0; errs = 0; lat = -1; extra = 0; d = '0;
    for (int c = 1; c <= 3000 && lat < 0; c++) begin
      @(posedge mclk); #1;
      if (wb_cpu_ack_o || wb_cpu_err_o) begin
        lat = c - 1; acks = int'(wb_cpu_ack_o); errs = int'(wb_cpu_err_o); d = wb_cpu_dat_o;
      end
    end
    if (lat < 0) chk("cpu_timeout", 64'd1, 64'd0);
    @(posedge mclk); #1;
    extra += int'(wb_cpu_ack_o) + int'(wb_cpu_err_o);
    wb_cpu_stb_i = 1'b0; wb_cpu_we_i = 1'b0;
    @(posedge mclk); #1;
    extra += int'(wb_cpu_ack_o) + int'(wb_cpu_err_o);
  endtask

  task automatic drain_chk();
    for (int c = 0; c < 500; c++) begin
      @(posedge mclk); #1;
      if (c >= 2 && !wb_app_stb_o && burst_q.size() >= exp_q.size()) break;
    end
    chk("drain_idle", 64'(wb_app_stb_o), 64'd0);
    chk("burst_cnt", 64'(burst_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < burst_q.size() && i < exp_q.size(); i++) chk("burst_adr", 64'(burst_q[i]), 64'(exp_q[i]));
    burst_q.delete();
    exp_q.delete();
  endtask

  // Model works on whole lines: which tag each index holds and which bursts must appear.
  task automatic do_read(input logic [31:0] a, input bit we, input bit drain);
    logic [31:0] base, nb, d;
    logic [3:0]  idx, ni;
    bit exp_hit, exp_err;
    int acks, errs, lat, extra;
    idx = a[10:7];
    base = {a[31:7], 7'b0};
    exp_hit = 1'b0;
    exp_err = we;
    if (!we) begin
      exp_hit = vld[idx] && tg_m[idx] == a[31:11];
      if (!exp_hit) begin
        exp_q.push_back(base);
        vld[idx] = 1'b0;
        if (nexp == inj) exp_err = 1'b1;
        else begin vld[idx] = 1'b1; tg_m[idx] = a[31:11]; end
        nexp++;
        if (!exp_err && !cfg_pfet_dis) begin
          nb = base + 32'd128;
          ni = nb[10:7];
          if (!(vld[ni] && tg_m[ni] == nb[31:11]) && !(cfg_ntag_pfet_dis && idx == 4'hF)) begin
            exp_q.push_back(nb);
            vld[ni] = 1'b0;
            if (nexp != inj) begin vld[ni] = 1'b1; tg_m[ni] = nb[31:11]; end
            nexp++;
          end
        end
      end
    end
    cpu_req(a, we, d, acks, errs, lat, extra);
    chk("cpu_ack", 64'(acks), 64'(!exp_err));
    chk("cpu_err", 64'(errs), 64'(exp_err));
    if (!exp_err) chk("rdata", 64'(d), 64'(memw(a)));
    chk("extra_pulse", 64'(extra), 64'd0);
    if (exp_hit && prev_drained) chk("hit_lat", 64'(lat), 64'd2);
    if (drain) drain_chk();
    prev_drained = drain;
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 16; i++) begin vld[i] = 1'b0; tg_m[i] = '0; end
    repeat (10) @(posedge mclk);
    #1;
    chk("rst_dat", 64'(wb_cpu_dat_o), 64'd0);
    chk("rst_ctl", 64'({wb_cpu_ack_o, wb_cpu_err_o, wb_app_stb_o, wb_app_we_o, wb_app_sel_o, wb_app_bl_o}), 64'd0);
    chk("rst_app_adr", 64'(wb_app_adr_o), 64'd0);
    chk("rst_app_dat", 64'(wb_app_dat_o), 64'd0);
    @(negedge mclk);
    rst_n = 1'b1;
    do_read(32'h0, 1'b0, 1'b1);
    for (int i = 1; i < 32; i++) do_read(32'(i * 4), 1'b0, 1'b1);
    do_read(32'h10, 1'b1, 1'b1);
    do_read(32'h10, 1'b0, 1'b1);
    do_read(32'h80, 1'b0, 1'b1);
    cfg_pfet_dis = 1'b0;
    do_read(32'h800, 1'b0, 1'b1);
    do_read(32'h0, 1'b0, 1'b1);
    do_read(32'h84, 1'b0, 1'b1);
    do_read(32'h803, 1'b0, 1'b1);
    cfg_ntag_pfet_dis = 1'b1;
    do_read(32'h780, 1'b0, 1'b1);
    do_read(32'h7FC, 1'b0, 1'b1);
    cfg_ntag_pfet_dis = 1'b0;
    do_read(32'hF80, 1'b0, 1'b1);
    do_read(32'h1004, 1'b0, 1'b1);
    do_read(32'h2000, 1'b0, 1'b0);
    do_read(32'h2088, 1'b0, 1'b1);
    inj = nexp; err_at = 5;
    do_read(32'h3000, 1'b0, 1'b1);
    do_read(32'h3000, 1'b0, 1'b1);
    inj = nexp + 1; err_at = 17;
    do_read(32'h4000, 1'b0, 1'b1);
    do_read(32'h4080, 1'b0, 1'b1);
    inj = -1;
    do_read(32'hFFFF_FF84, 1'b0, 1'b1);
    for (int i = 0; i < 1024; i++) begin
      if (i % 64 == 0) begin
        cfg_pfet_dis = 1'($urandom_range(0, 1));
        cfg_ntag_pfet_dis = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) begin inj = nexp + 1; err_at = $urandom_range(0, 31); end
      end
      a = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 15) == 0) a = a | 32'hFFFF_F000;
      do_read(a, $urandom_range(0, 31) == 0, (i % 64 == 63) || ($urandom_range(0, 3) != 0));
    end
    chk("ack_err_overlap", 64'(both_bad), 64'd0);
    chk("app_adr_bl_stable", 64'(adr_bad), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/icache_wb_top.md
ICACHE_WB_TOP -- requirements
Module: icache_wb_top

Interface
REQ-001 Parameters: WB_AW 32 address width; WB_DW 32 data width; TAG_MEM_WD 22 tag entry width (21-bit tag + valid); TAG_MEM_DP 16 tag entries; CACHELINES 16 lines; CACHESIZE 32 words per line.
REQ-002 mclk  in  1  sole clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 cfg_pfet_dis  in  1  1 = next-line prefetch disabled.
REQ-005 cfg_ntag_pfet_dis  in  1  1 = suppress prefetch when the next line's index wraps from 15 to 0.
REQ-006 wb_cpu_stb_i in 1 request; wb_cpu_adr_i in 32 byte address; wb_cpu_we_i in 1 write; wb_cpu_dat_i in 32 write data (unused); wb_cpu_sel_i in 4 byte enables (ignored, full word returned).
REQ-007 wb_cpu_dat_o out 32 read data; wb_cpu_ack_o out 1 ack pulse; wb_cpu_err_o out 1 error pulse.
REQ-008 wb_app_stb_o out 1 burst request; wb_app_adr_o out 32 line base address; wb_app_we_o out 1 (always 0); wb_app_dat_o out 32 (always 0); wb_app_sel_o out 4 (0xF while stb); wb_app_bl_o out 10 burst length in words.
REQ-009 wb_app_dat_i in 32 read data; wb_app_ack_i in 1 per-word ack; wb_app_lack_i in 1 last-word ack (asserted with the final ack_i); wb_app_err_i in 1 error.

Function
REQ-010 Direct-mapped, read-only: offset = adr[6:2], index = adr[10:7], tag = adr[31:11]; adr[1:0] ignored.
REQ-011 Data store: 512 x 32 synchronous-read array addressed {index, offset}; tag store: 16 x 22 registers {valid, tag}.
REQ-012 FSM states: IDLE, LOOKUP, RESP, REFILL, DONE, PREFETCH.
REQ-013 IDLE: stb_i=1 and we_i=0 -> issue data-array read, go LOOKUP; stb_i=1 and we_i=1 -> pulse err_o one cycle (no ack), go DONE.
REQ-014 LOOKUP hit (valid and tag match): ack_o=1 for one cycle with dat_o = array word; hit latency 2 clocks from the stb_i sampling edge to ack_o asserted; go DONE.
REQ-015 LOOKUP miss: go REFILL; assert app_stb_o, app_adr_o = {adr[31:7], 7'b0}, app_bl_o = 32, held constant until lack_i.
REQ-016 REFILL: each app_ack_i writes app_dat_i to array word {index, n}, n incrementing from 0; on lack_i deassert app_stb_o next edge, write tag entry {1, tag}, then re-enter LOOKUP (guaranteed hit).
REQ-017 app_err_i during any burst: abort burst, leave line invalid; for a demand refill pulse cpu err_o one cycle and go DONE; for a prefetch return to IDLE silently.
REQ-018 DONE: lasts exactly one cycle, stb_i ignored (requester may still hold stb_i on the edge after ack); then IDLE. Exactly one ack/err per request.
REQ-019 Prefetch: after a demand refill completes and cpu ack is issued, if cfg_pfet_dis=0, next line (line base + 128) is not valid-and-matching, and not (cfg_ntag_pfet_dis=1 and index=15), enter PREFETCH: same burst protocol as REFILL for the next line, tag written on lack_i.
REQ-020 A CPU request arriving during PREFETCH is stalled (no ack) until the prefetch burst completes, then served from IDLE normally.
REQ-021 Refill of an index overwrites the resident line (tag marked invalid at burst start, valid on completion).
REQ-022 ack_o, err_o never asserted simultaneously; app_stb_o never asserted outside REFILL/PREFETCH.

Reset
REQ-023 rst_n=0 at a rising edge: FSM -> IDLE, all 16 valid bits cleared, any burst abandoned; outputs 0: wb_cpu_dat_o, ack_o, err_o, app_stb_o, app_adr_o, app_we_o, app_dat_o, app_sel_o, app_bl_o.
REQ-024 Data array contents not reset; reset mid-burst leaves line invalid.

Verification
REQ-025 Reset held 10 cycles -> all outputs 0; first read after release misses.
REQ-026 Cold read 0x0 -> app_stb_o, app_adr_o=0x0, app_bl_o=32, 32 acks with lack on last; cpu ack once with dat_o = memory word 0; no second ack while stb held one extra cycle.
REQ-027 Sequential reads 0x4..0x7C after fill -> all hits, no app_stb_o, ack 2 clocks after stb, data matches memory.
REQ-028 cfg_pfet_dis=0: read 0x0 fill triggers prefetch burst at 0x80; later read 0x80 -> hit, no app traffic; with cfg_pfet_dis=1 read 0x80 -> demand refill.
REQ-029 Conflict: read 0x800 after 0x0 (both index 0) -> refill adr 0x800; reread 0x0 -> miss and refill adr 0x0; 1024 random word addresses all return memory contents.
REQ-030 Write request (we_i=1, adr 0x10) -> err_o one-cycle pulse, no ack_o, no app traffic, cache contents unchanged.
